// File: rtl/sram_serial_reader_if.sv
// Bus bundle for sram_serial_reader: command port, SRAM read port and
// bit-serial output port. The reader is the master of all three; the
// slave view is what the command source, SRAM and serial consumer see.
interface sram_serial_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);

  // Command port
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH-1:0] burst_len;
  logic                  busy;
  logic                  done;
  logic                  err;

  // SRAM read port
  logic                  sram_r_en;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_data_out;
  logic                  sram_data_valid;

  // Serial output port
  logic                  serial_out;
  logic                  serial_valid;
  logic                  serial_ready;
  logic                  serial_last;

  modport master (
    input  start, start_addr, burst_len,
    input  sram_data_out, sram_data_valid,
    input  serial_ready,
    output busy, done, err,
    output sram_r_en, sram_addr,
    output serial_out, serial_valid, serial_last
  );

  modport slave (
    output start, start_addr, burst_len,
    output sram_data_out, sram_data_valid,
    output serial_ready,
    input  busy, done, err,
    input  sram_r_en, sram_addr,
    input  serial_out, serial_valid, serial_last
  );

endinterface

// File: rtl/sram_serial_reader.sv
// sram_serial_reader: on a start command, reads burst_len+1 consecutive
// SRAM words (address wraps modulo 2^ADDR_WIDTH) and streams each word
// MSB-first on a ready/valid bit-serial port. A missing read response
// aborts the command after TIMEOUT wait cycles and sets a sticky err.
// Every output is a decode of registered state, so no input reaches an
// output combinationally.
module sram_serial_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                 clk,
  input  logic                 arst_n,
  sram_serial_reader_if.master bus
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);

  localparam logic [BCW-1:0]        BIT_LAST  = BCW'(DATA_WIDTH - 1);
  localparam logic [TW-1:0]         TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e                state_q,    state_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [BCW-1:0]        bit_cnt_q,  bit_cnt_d;
  logic [TW-1:0]         timer_q,    timer_d;
  logic [DATA_WIDTH-1:0] shift_q,    shift_d;
  logic                  err_q,      err_d;

  // State register and datapath flops; everything clears on reset so an
  // aborted command leaves no residue.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      word_cnt_q <= '0;
      bit_cnt_q  <= '0;
      timer_q    <= '0;
      shift_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_cnt_q <= word_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      timer_q    <= timer_d;
      shift_q    <= shift_d;
      err_q      <= err_d;
    end
  end

  // Next-state and datapath update for the read/shift sequence.
  // NOTE: every signal gets its hold value first so no path through the
  // case leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    word_cnt_d = word_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    timer_d    = timer_q;
    shift_d    = shift_q;
    err_d      = err_q;

    unique case (state_q)
      S_IDLE: begin
        // start is only looked at here, so a start while busy is dropped
        if (bus.start) begin
          addr_d     = bus.start_addr;
          word_cnt_d = bus.burst_len;
          err_d      = 1'b0;
          state_d    = S_REQ;
        end
      end

      S_REQ: begin
        timer_d = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // Data wins over a timeout landing in the same cycle
        if (bus.sram_data_valid) begin
          shift_d   = bus.sram_data_out;
          bit_cnt_d = '0;
          state_d   = S_SHIFT;
        end else if (timer_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_SHIFT: begin
        // serial_valid is 1 throughout SHIFT, so ready alone means transfer
        if (bus.serial_ready) begin
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q + BCW'(1);
          if (bit_cnt_q == BIT_LAST) begin
            if (word_cnt_q != '0) begin
              word_cnt_d = word_cnt_q - ADDR_ONE;
              addr_d     = addr_q + ADDR_ONE;
              state_d    = S_REQ;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decodes of registered state only.
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.err          = err_q;
  assign bus.sram_r_en    = (state_q == S_REQ);
  assign bus.sram_addr    = addr_q;
  assign bus.serial_valid = (state_q == S_SHIFT);
  assign bus.serial_out   = (state_q == S_SHIFT) && shift_q[DATA_WIDTH-1];
  assign bus.serial_last  = (state_q == S_SHIFT) && (bit_cnt_q == BIT_LAST);

endmodule

// File: doc/sram_serial_reader.md
# sram_serial_reader

Read-side companion to the serial-load write path of `sram_top`. The block accepts a start command with a base address and a burst length, and issues one-cycle `r_en` read requests to the SRAM. It captures each returned word when `data_valid` is high and shifts the word out MSB-first on a serial port with ready/valid backpressure. It sits between `sram_top` and any bit-serial consumer, such as a scan-out pin or a loopback checker.

## Interface
- `DATA_WIDTH`, 8, SRAM word width; equals `sram_top` COLS
- `ADDR_WIDTH`, 4, SRAM address width; equals `sram_top` ROWS
- `TIMEOUT`, 16, cycles to wait for `sram_data_valid` before aborting
- `clk`  in  1  single clock, rising edge
- `arst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  command strobe; sampled only while `busy`=0
- `start_addr`  in  ADDR_WIDTH  first word address
- `burst_len`  in  ADDR_WIDTH  number of words minus 1 (range 1..2^ADDR_WIDTH words)
- `sram_r_en`  out  1  read request to SRAM
- `sram_addr`  out  ADDR_WIDTH  read address to SRAM
- `sram_data_out`  in  DATA_WIDTH  SRAM read data
- `sram_data_valid`  in  1  SRAM read data qualifier
- `serial_out`  out  1  current bit
- `serial_valid`  out  1  `serial_out` is meaningful
- `serial_ready`  in  1  consumer accepts bit this cycle
- `serial_last`  out  1  current bit is LSB of a word
- `busy`  out  1  command in progress
- `done`  out  1  one-cycle pulse when a command ends
- `err`  out  1  sticky timeout flag; cleared by next accepted `start`

## Operation
- Reset values: state IDLE; all outputs 0; shift register, counters and address register 0.
- FSM states are IDLE, REQ, WAIT, SHIFT and DONE.
- IDLE:
  - `start`=1 latches `start_addr` and `burst_len` into a word counter, clears `err`, and goes to REQ.
  - `busy`=1 in every state except IDLE.
- REQ: `sram_r_en`=1 for exactly one cycle, then WAIT.
- `sram_addr` equals the latched address from REQ through capture; it is stable in REQ, WAIT and SHIFT.
- WAIT:
  - On `sram_data_valid`=1, load `sram_data_out` into the shift register, clear the bit counter, and go to SHIFT.
  - A timeout counter runs from 0. When it reaches TIMEOUT-1 without valid, set `err`=1 and go to DONE.
- `sram_data_valid` outside WAIT is ignored.
- SHIFT:
  - `serial_valid`=1 and `serial_out`=shift register MSB.
  - A bit transfers when `serial_valid` and `serial_ready` are both 1. On transfer the register shifts left by 1 and the bit counter increments.
  - With `serial_ready`=0, `serial_out`, `serial_last` and all state hold.
  - `serial_last`=1 while bit counter = DATA_WIDTH-1.
- On transfer of the last bit:
  - If the word counter is nonzero: decrement it, set the address to addr+1 modulo 2^ADDR_WIDTH (F wraps to 0), and go to REQ.
  - Otherwise go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` while `busy`=1 is ignored. It is not queued.
- Asynchronous reset mid-command aborts immediately. There is no partial-word flush. Outputs return to reset values.

## Timing
- Outputs are registered state decodes; none has a combinational path from an input.
- `start` is sampled at edge k; `sram_r_en`=1 in cycle k+1.
- If `sram_data_valid` arrives L cycles after `r_en`, the first `serial_valid` occurs at cycle k+2+L. The `sram_top` nominal value is L=1.
- With `serial_ready` held at 1:
  - One word takes DATA_WIDTH serial cycles.
  - The gap between words is 1 REQ cycle plus L cycles.
  - `done` asserts the cycle after the final bit transfer.
- Timeout: `err` and `done` rise TIMEOUT+1 cycles after the `r_en` cycle.
- `serial_valid` drops in the cycle after the last bit of each word transfers. There are no bubbles within a word except those caused by backpressure.

## Test plan
- Single word:
  - Stimulus: preload addr 3 = 8'hA5 through the serial write path; `start_addr`=3, `burst_len`=0, `serial_ready`=1.
  - Response: exactly one `r_en` pulse, with `sram_addr`=3.
  - Response: serial bits 1,0,1,0,0,1,0,1, with `serial_last` on the 8th bit.
  - Response: `done` pulses once and `busy` returns to 0.
- Burst with wrap:
  - Stimulus: addr F=8'h3C, addr 0=8'hC3; `start_addr`=F, `burst_len`=1.
  - Response: two `r_en` pulses, at addr F then 0; stream 0x3C then 0xC3; `serial_last` twice.
- Backpressure:
  - Stimulus: word 8'h96; `serial_ready` toggles 1,0,0,1,... in a pseudo-random pattern.
  - Response: exactly 8 transferred bits = 1,0,0,1,0,1,1,0, with no duplication or loss; `serial_out` stable while stalled.
- Timeout:
  - Stimulus: SRAM model never asserts `sram_data_valid`.
  - Response: `err`=1 and a `done` pulse, 17 cycles after `r_en`; no `serial_valid`.
  - Response: the next `start` clears `err`.
- Start while busy:
  - Stimulus: pulse `start` with addr 5 during SHIFT of addr 3.
  - Response: addr 5 is never requested; a single `done` pulse.
- Reset mid-shift:
  - Stimulus: drop `arst_n` after bit 3 of a word.
  - Response: all outputs 0 immediately.
  - Response: a new `start` after release reads correct data from bit 7.
